// File: rtl/plot_framebuffer_if.sv
// Sample stream into the plot frame buffer: one Y value per column, valid/ready.
interface plot_framebuffer_if #(
  parameter int YW = 6
);
  logic          s_valid;
  logic [YW-1:0] s_y;
  logic          s_ready;

  modport master (output s_valid, s_y, input s_ready);
  modport slave  (input s_valid, s_y, output s_ready);
endinterface

// File: rtl/plot_framebuffer.sv
// Double-buffered ROWS x COLS bitmap: rasterises a column stream into the back
// bank (dot or bar) and serves two registered row reads from the front bank.
module plot_framebuffer #(
  parameter int COLS = 64,
  parameter int ROWS = 64,
  parameter int YW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  plot_framebuffer_if.slave s,
  input  logic            swap_req,
  output logic            frame_done,
  input  logic            r_en,
  input  logic [YW-1:0]   row_0_sel,
  input  logic [YW-1:0]   row_1_sel,
  output logic [COLS-1:0] row_0,
  output logic [COLS-1:0] row_1
);

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, READY} state_e;

  state_e                            state_q, state_d;
  logic                              mode_q, mode_d;
  logic                              front_q, front_d;
  logic [YW-1:0]                     row_q, row_d;
  logic [CW-1:0]                     col_q, col_d;
  logic                              frame_done_q, frame_done_d;
  logic [COLS-1:0]                   row_0_q, row_0_d, row_1_q, row_1_d;
  logic [1:0][ROWS-1:0][COLS-1:0]    bank_q, bank_d;

  logic          back;
  logic [YW-1:0] y_clamp;

  assign back    = ~front_q;
  assign y_clamp = (int'(s.s_y) >= ROWS) ? YW'(ROWS - 1) : s.s_y;

  // busy/s_ready depend only on the state register
  assign busy       = (state_q != IDLE);
  assign s.s_ready  = (state_q == FILL);
  assign frame_done = frame_done_q;
  assign row_0      = row_0_q;
  assign row_1      = row_1_q;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    front_d      = front_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    bank_d       = bank_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          row_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        bank_d[back][row_q] = '0;
        if (int'(row_q) == ROWS - 1) begin
          row_d   = '0;
          col_d   = '0;
          state_d = FILL;
        end else begin
          row_d = row_q + YW'(1);
        end
      end
      FILL: begin
        if (s.s_valid) begin
          for (int r = 0; r < ROWS; r++) begin
            if (mode_q ? (r >= int'(y_clamp)) : (r == int'(y_clamp)))
              bank_d[back][r][col_q] = 1'b1;
          end
          if (int'(col_q) == COLS - 1) begin
            col_d   = '0;
            state_d = READY;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      READY: begin
        if (swap_req) begin
          front_d      = ~front_q;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads see front_q before any same-edge swap, so a colliding read returns the old bank.
  always_comb begin
    row_0_d = row_0_q;
    row_1_d = row_1_q;
    if (r_en) begin
      row_0_d = (int'(row_0_sel) < ROWS) ? bank_q[front_q][row_0_sel] : '0;
      row_1_d = (int'(row_1_sel) < ROWS) ? bank_q[front_q][row_1_sel] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      front_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      row_0_q      <= '0;
      row_1_q      <= '0;
      bank_q       <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      front_q      <= front_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      row_0_q      <= row_0_d;
      row_1_q      <= row_1_d;
      bank_q       <= bank_d;
    end
  end

endmodule
